// File: rtl/nice_icb_mem_slave_if.sv
// ICB command/response channel bundle between a bus master and the memory slave.
interface nice_icb_mem_slave_if;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [31:0] icb_cmd_wdata;
    logic [1:0]  icb_cmd_size;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [31:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_size,
        input  icb_cmd_ready,
        input  icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        output icb_rsp_ready
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_size,
        output icb_cmd_ready,
        output icb_rsp_valid, icb_rsp_rdata, icb_rsp_err,
        input  icb_rsp_ready
    );
endinterface

// File: rtl/nice_icb_mem_slave.sv
// Byte-addressed big-endian ICB memory slave with in-order, latency-aged
// response queue, optional periodic command stall and a backdoor preload port.
module nice_icb_mem_slave #(
    parameter int MEM_BYTES   = 4096,
    parameter int RSP_LAT     = 1,
    parameter int OUTSTANDING = 2,
    parameter int STALL_EVERY = 0
) (
    input  logic                       nice_clk,
    input  logic                       nice_rst_n,
    nice_icb_mem_slave_if.slave        icb,
    input  logic                       bk_wr_en,
    input  logic [31:0]                bk_addr,
    input  logic [7:0]                 bk_wdata,
    output logic [3:0]                 pend_cnt,
    output logic [15:0]                err_cnt
);
    localparam int AW = $clog2(MEM_BYTES);
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [7:0]    r_mem     [MEM_BYTES];
    logic [31:0]   r_q_rdata [OUTSTANDING];
    logic          r_q_err   [OUTSTANDING];
    logic [3:0]    r_q_age   [OUTSTANDING];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [3:0]    r_count;
    logic [15:0]   r_err_cnt;
    logic [31:0]   r_acc_cnt;
    logic          r_stall;
    logic          r_alive;

    logic [2:0]    w_nbytes;
    logic [AW-1:0] w_idx;
    logic          w_misalign;
    logic          w_oob;
    logic          w_err;
    logic [31:0]   w_rd_raw;
    logic [31:0]   w_rdata;
    logic [31:0]   w_wal;
    logic          w_accept;
    logic          w_head_valid;
    logic          w_retire;

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Ready depends only on registered state; r_alive holds it low through reset.
    assign icb.icb_cmd_ready = r_alive && (r_count < 4'(OUTSTANDING)) && !r_stall;
    assign w_accept          = icb.icb_cmd_valid && icb.icb_cmd_ready;
    assign w_idx             = icb.icb_cmd_addr[AW-1:0];
    assign w_head_valid      = (r_count != 4'd0) && (r_q_age[r_rd_ptr] >= 4'(RSP_LAT));
    assign w_retire          = w_head_valid && icb.icb_rsp_ready;

    assign icb.icb_rsp_valid = w_head_valid;
    assign icb.icb_rsp_rdata = w_head_valid ? r_q_rdata[r_rd_ptr] : '0;
    assign icb.icb_rsp_err   = w_head_valid && r_q_err[r_rd_ptr];
    assign pend_cnt          = r_count;
    assign err_cnt           = r_err_cnt;

    // Decode size/alignment/range, gather big-endian read data, left-align write data.
    always_comb begin
        w_nbytes = 3'd0;
        case (icb.icb_cmd_size)
            2'd0:    w_nbytes = 3'd1;
            2'd1:    w_nbytes = 3'd2;
            2'd2:    w_nbytes = 3'd4;
            default: w_nbytes = 3'd0;
        endcase
        w_misalign = ((icb.icb_cmd_size == 2'd1) && icb.icb_cmd_addr[0]) ||
                     ((icb.icb_cmd_size == 2'd2) && (icb.icb_cmd_addr[1:0] != 2'b00));
        w_oob      = ({1'b0, icb.icb_cmd_addr} + {30'b0, w_nbytes}) > 33'(MEM_BYTES);
        w_err      = (icb.icb_cmd_size == 2'd3) || w_misalign || w_oob;
        w_rd_raw   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (3'(i) < w_nbytes) w_rd_raw = {w_rd_raw[23:0], r_mem[w_idx + AW'(i)]};
        end
        w_rdata = (icb.icb_cmd_read && !w_err) ? w_rd_raw : '0;
        w_wal   = icb.icb_cmd_wdata << {3'd4 - w_nbytes, 3'b000};
    end

    // Memory array: bus writes first, backdoor last so it wins a same-byte collision.
    always_ff @(posedge nice_clk) begin
        if (w_accept && !icb.icb_cmd_read && !w_err) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (3'(i) < w_nbytes) r_mem[w_idx + AW'(i)] <= w_wal[8*(3-i) +: 8];
            end
        end
        if (bk_wr_en && (bk_addr < 32'(MEM_BYTES))) r_mem[bk_addr[AW-1:0]] <= bk_wdata;
    end

    // Response queue, age timers, occupancy, error counter and stall generator.
    always_ff @(posedge nice_clk or negedge nice_rst_n) begin
        if (!nice_rst_n) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                r_q_rdata[i] <= '0;
                r_q_err[i]   <= 1'b0;
                r_q_age[i]   <= '0;
            end
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
            r_acc_cnt <= '0;
            r_stall   <= 1'b0;
            r_alive   <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            // A new entry starts at age 1: the accept edge counts as its first cycle.
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                if (w_accept && (r_wr_ptr == PW'(i))) begin
                    r_q_rdata[i] <= w_rdata;
                    r_q_err[i]   <= w_err;
                    r_q_age[i]   <= 4'd1;
                end else if (r_q_age[i] < 4'(RSP_LAT)) begin
                    r_q_age[i] <= r_q_age[i] + 4'd1;
                end
            end
            if (w_accept) r_wr_ptr <= f_next(r_wr_ptr);
            if (w_retire) r_rd_ptr <= f_next(r_rd_ptr);
            case ({w_accept, w_retire})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
            if (w_retire && r_q_err[r_rd_ptr] && (r_err_cnt != 16'hFFFF))
                r_err_cnt <= r_err_cnt + 16'd1;
            r_stall <= 1'b0;
            if (w_accept) begin
                if ((STALL_EVERY != 0) && (r_acc_cnt == 32'(STALL_EVERY - 1))) begin
                    r_acc_cnt <= '0;
                    r_stall   <= 1'b1;
                end else begin
                    r_acc_cnt <= r_acc_cnt + 32'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_nice_icb_mem_slave.sv
// Directed bench for nice_icb_mem_slave: three instances (default, deep latency,
// periodic stall) with a per-instance in-order expected-response queue.
module tb_nice_icb_mem_slave;
    localparam int MEM = 4096;

    typedef struct packed {
        logic        chk;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        bk_wr_en;
    logic [31:0] bk_addr;
    logic [7:0]  bk_wdata;
    logic [31:0] c_addr;
    logic        c_read;
    logic [31:0] c_wdata;
    logic [1:0]  c_size;
    logic        c_valid  [3];
    logic        c_rready [3];
    logic        w_ready  [3];
    logic        w_rvalid [3];
    logic [31:0] w_rdata  [3];
    logic        w_rerr   [3];
    logic [3:0]  w_pend   [3];
    logic [15:0] w_errc   [3];

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];

    nice_icb_mem_slave_if ifa ();
    nice_icb_mem_slave_if ifb ();
    nice_icb_mem_slave_if ifc ();

    assign ifa.icb_cmd_valid = c_valid[0];
    assign ifb.icb_cmd_valid = c_valid[1];
    assign ifc.icb_cmd_valid = c_valid[2];
    assign ifa.icb_rsp_ready = c_rready[0];
    assign ifb.icb_rsp_ready = c_rready[1];
    assign ifc.icb_rsp_ready = c_rready[2];
    assign {ifa.icb_cmd_addr, ifa.icb_cmd_read, ifa.icb_cmd_wdata, ifa.icb_cmd_size} = {c_addr, c_read, c_wdata, c_size};
    assign {ifb.icb_cmd_addr, ifb.icb_cmd_read, ifb.icb_cmd_wdata, ifb.icb_cmd_size} = {c_addr, c_read, c_wdata, c_size};
    assign {ifc.icb_cmd_addr, ifc.icb_cmd_read, ifc.icb_cmd_wdata, ifc.icb_cmd_size} = {c_addr, c_read, c_wdata, c_size};
    assign w_ready[0]  = ifa.icb_cmd_ready;
    assign w_ready[1]  = ifb.icb_cmd_ready;
    assign w_ready[2]  = ifc.icb_cmd_ready;
    assign w_rvalid[0] = ifa.icb_rsp_valid;
    assign w_rvalid[1] = ifb.icb_rsp_valid;
    assign w_rvalid[2] = ifc.icb_rsp_valid;
    assign w_rdata[0]  = ifa.icb_rsp_rdata;
    assign w_rdata[1]  = ifb.icb_rsp_rdata;
    assign w_rdata[2]  = ifc.icb_rsp_rdata;
    assign w_rerr[0]   = ifa.icb_rsp_err;
    assign w_rerr[1]   = ifb.icb_rsp_err;
    assign w_rerr[2]   = ifc.icb_rsp_err;

    nice_icb_mem_slave #(.MEM_BYTES(MEM), .RSP_LAT(1), .OUTSTANDING(2), .STALL_EVERY(0)) dut0 (
        .nice_clk(clk), .nice_rst_n(rst_n), .icb(ifa),
        .bk_wr_en(bk_wr_en), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .pend_cnt(w_pend[0]), .err_cnt(w_errc[0]));

    nice_icb_mem_slave #(.MEM_BYTES(MEM), .RSP_LAT(3), .OUTSTANDING(2), .STALL_EVERY(0)) dut1 (
        .nice_clk(clk), .nice_rst_n(rst_n), .icb(ifb),
        .bk_wr_en(bk_wr_en), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .pend_cnt(w_pend[1]), .err_cnt(w_errc[1]));

    nice_icb_mem_slave #(.MEM_BYTES(MEM), .RSP_LAT(1), .OUTSTANDING(2), .STALL_EVERY(4)) dut2 (
        .nice_clk(clk), .nice_rst_n(rst_n), .icb(ifc),
        .bk_wr_en(bk_wr_en), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .pend_cnt(w_pend[2]), .err_cnt(w_errc[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input int idx, input exp_t e);
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int idx, input logic [31:0] d, input logic er);
        exp_t e;
        logic have;
        have = 1'b0;
        e    = '0;
        case (idx)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        n_tests++;
        assert (have) else begin
            n_fail++;
            $error("FAIL rsp_unexpected dut%0d: got rdata 0x%08h err %0b expected no response", idx, d, er);
        end
        if (have) begin
            check($sformatf("rsp_err dut%0d", idx), {31'b0, er}, {31'b0, e.err});
            if (e.chk) check($sformatf("rsp_rdata dut%0d", idx), d, e.data);
        end
    endtask

    // Retire-side monitor: every handshaken response is matched against the queue head.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
                if (w_rvalid[i] && c_rready[i]) sb_pop(i, w_rdata[i], w_rerr[i]);
            end
        end
    end

    task automatic bk(input logic [31:0] a, input logic [7:0] d);
        bk_wr_en = 1'b1;
        bk_addr  = a;
        bk_wdata = d;
        tick();
        bk_wr_en = 1'b0;
    endtask

    task automatic send(input int idx, input logic rd, input logic [31:0] a, input logic [31:0] wd,
                        input logic [1:0] sz, input logic [31:0] ed, input logic ee);
        logic acc;
        acc          = 1'b0;
        c_read       = rd;
        c_addr       = a;
        c_wdata      = wd;
        c_size       = sz;
        c_valid[idx] = 1'b1;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            if (w_ready[idx]) begin
                acc = 1'b1;
                sb_push(idx, exp_t'({rd | ee, ee, ed}));
            end
            @(posedge clk);
            #1;
        end
        c_valid[idx] = 1'b0;
        n_tests++;
        assert (acc) else begin
            n_fail++;
            $error("FAIL cmd_accept dut%0d: got accepted=0 expected accepted=1 within 100 cycles", idx);
        end
    endtask

    task automatic wait_idle(input int idx);
        for (int k = 0; k < 100 && w_pend[idx] != 4'd0; k++) tick();
        check($sformatf("drain dut%0d pend_cnt", idx), {28'b0, w_pend[idx]}, 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        bk_wr_en = 1'b0;
        bk_addr  = '0;
        bk_wdata = '0;
        c_addr   = '0;
        c_read   = 1'b0;
        c_wdata  = '0;
        c_size   = '0;
        for (int i = 0; i < 3; i++) begin
            c_valid[i]  = 1'b0;
            c_rready[i] = 1'b1;
        end
        c_rready[1] = 1'b0;

        // Reset state
        repeat (3) tick();
        check("reset cmd_ready", {31'b0, w_ready[0]}, 32'd0);
        check("reset rsp_valid", {31'b0, w_rvalid[0]}, 32'd0);
        check("reset rsp_rdata", w_rdata[0], 32'd0);
        check("reset pend_cnt", {28'b0, w_pend[0]}, 32'd0);
        check("reset err_cnt", {16'b0, w_errc[0]}, 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) check($sformatf("ready after release dut%0d", i), {31'b0, w_ready[i]}, 32'd1);

        // Backdoor preload (shared by all instances)
        bk(32'h0, 8'h01); bk(32'h1, 8'h02); bk(32'h2, 8'h03); bk(32'h3, 8'h04);
        bk(MEM - 4, 8'hA1); bk(MEM - 3, 8'hA2); bk(MEM - 2, 8'hA3); bk(MEM - 1, 8'hA4);

        // Word read, one-cycle latency
        check("idle rsp_valid", {31'b0, w_rvalid[0]}, 32'd0);
        send(0, 1'b1, 32'h0, '0, 2'd2, 32'h01020304, 1'b0);
        check("lat1 rsp_valid", {31'b0, w_rvalid[0]}, 32'd1);
        check("lat1 pend_cnt", {28'b0, w_pend[0]}, 32'd1);
        wait_idle(0);

        // Lane mapping for writes and sub-word reads
        send(0, 1'b0, 32'h10, 32'hAABBCCDD, 2'd2, '0, 1'b0);
        send(0, 1'b1, 32'h12, '0, 2'd0, 32'h000000CC, 1'b0);
        send(0, 1'b1, 32'h10, '0, 2'd1, 32'h0000AABB, 1'b0);
        send(0, 1'b1, 32'h13, '0, 2'd0, 32'h000000DD, 1'b0);
        send(0, 1'b0, 32'h14, 32'hFFFF1234, 2'd1, '0, 1'b0);
        send(0, 1'b0, 32'h16, 32'h00005678, 2'd1, '0, 1'b0);
        send(0, 1'b1, 32'h14, '0, 2'd2, 32'h12345678, 1'b0);
        send(0, 1'b0, 32'h11, 32'hABCDEFEE, 2'd0, '0, 1'b0);
        send(0, 1'b1, 32'h10, '0, 2'd2, 32'hAAEECCDD, 1'b0);
        send(0, 1'b1, MEM - 4, '0, 2'd2, 32'hA1A2A3A4, 1'b0);
        send(0, 1'b1, MEM - 2, '0, 2'd1, 32'h0000A3A4, 1'b0);
        wait_idle(0);

        // Error cases
        send(0, 1'b1, 32'h2, '0, 2'd2, 32'h0, 1'b1);
        send(0, 1'b1, 32'h0, '0, 2'd3, 32'h0, 1'b1);
        send(0, 1'b1, MEM - 2, '0, 2'd2, 32'h0, 1'b1);
        wait_idle(0);
        check("err_cnt after 3 errors", {16'b0, w_errc[0]}, 32'd3);
        send(0, 1'b0, 32'h12, 32'h11223344, 2'd2, '0, 1'b1);
        send(0, 1'b0, MEM, 32'h00000077, 2'd0, '0, 1'b1);
        bk(MEM, 8'h55);
        send(0, 1'b1, 32'h10, '0, 2'd2, 32'hAAEECCDD, 1'b0);
        send(0, 1'b1, 32'h0, '0, 2'd2, 32'h01020304, 1'b0);
        wait_idle(0);
        check("err_cnt after 5 errors", {16'b0, w_errc[0]}, 32'd5);

        // Same-cycle backdoor and bus write to one byte
        bk_wr_en = 1'b1;
        bk_addr  = 32'h30;
        bk_wdata = 8'h99;
        send(0, 1'b0, 32'h30, 32'h00000011, 2'd0, '0, 1'b0);
        bk_wr_en = 1'b0;
        send(0, 1'b1, 32'h30, '0, 2'd0, 32'h00000099, 1'b0);
        wait_idle(0);

        // Stall after every 4th accept with continuous valid
        c_read       = 1'b1;
        c_addr       = 32'h0;
        c_size       = 2'd2;
        c_wdata      = '0;
        c_valid[2]   = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            check($sformatf("stall ready cyc%0d", i), {31'b0, w_ready[2]}, (i % 5 == 4) ? 32'd0 : 32'd1);
            if (w_ready[2]) sb_push(2, exp_t'({1'b1, 1'b0, 32'h01020304}));
            @(posedge clk);
            #1;
        end
        c_valid[2] = 1'b0;
        wait_idle(2);

        // RSP_LAT=3, OUTSTANDING=2: back-to-back reads with responses held off
        send(1, 1'b1, 32'h0, '0, 2'd2, 32'h01020304, 1'b0);
        check("lat3 valid early", {31'b0, w_rvalid[1]}, 32'd0);
        send(1, 1'b1, 32'h0, '0, 2'd1, 32'h00000102, 1'b0);
        c_addr     = 32'h2;
        c_size     = 2'd1;
        c_valid[1] = 1'b1;
        @(negedge clk);
        check("full cmd_ready", {31'b0, w_ready[1]}, 32'd0);
        check("full pend_cnt", {28'b0, w_pend[1]}, 32'd2);
        check("lat3 valid at age 2", {31'b0, w_rvalid[1]}, 32'd0);
        tick();
        check("lat3 valid at age 3", {31'b0, w_rvalid[1]}, 32'd1);
        check("lat3 head rdata", w_rdata[1], 32'h01020304);
        repeat (3) tick();
        check("held head rdata", w_rdata[1], 32'h01020304);
        check("held cmd_ready", {31'b0, w_ready[1]}, 32'd0);
        c_rready[1] = 1'b1;
        send(1, 1'b1, 32'h2, '0, 2'd1, 32'h00000304, 1'b0);
        wait_idle(1);

        // Reset with two pending responses; memory must survive
        c_rready[0] = 1'b0;
        send(0, 1'b1, 32'h10, '0, 2'd2, 32'hAAEECCDD, 1'b0);
        send(0, 1'b1, 32'h14, '0, 2'd1, 32'h00001234, 1'b0);
        check("pre-reset pend_cnt", {28'b0, w_pend[0]}, 32'd2);
        check("pre-reset cmd_ready", {31'b0, w_ready[0]}, 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async reset rsp_valid", {31'b0, w_rvalid[0]}, 32'd0);
        check("async reset pend_cnt", {28'b0, w_pend[0]}, 32'd0);
        check("async reset cmd_ready", {31'b0, w_ready[0]}, 32'd0);
        check("async reset rsp_rdata", w_rdata[0], 32'd0);
        check("async reset err_cnt", {16'b0, w_errc[0]}, 32'd0);
        q0.delete();
        q1.delete();
        q2.delete();
        repeat (2) tick();
        rst_n       = 1'b1;
        c_rready[0] = 1'b1;
        tick();
        check("ready after 2nd release", {31'b0, w_ready[0]}, 32'd1);
        send(0, 1'b1, 32'h10, '0, 2'd2, 32'hAAEECCDD, 1'b0);
        send(0, 1'b1, 32'h0, '0, 2'd2, 32'h01020304, 1'b0);
        wait_idle(0);
        check("scoreboards drained", q0.size() + q1.size() + q2.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/nice_icb_mem_slave.md
NICE_ICB_MEM_SLAVE -- requirements
Module: nice_icb_mem_slave

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 4096: byte capacity of the memory array; power of two, at least 16.
REQ-002 SHALL have parameter RSP_LAT, default 1: cycles from command accept to earliest rsp_valid; legal range 1..8.
REQ-003 SHALL have parameter OUTSTANDING, default 2: maximum accepted-but-unretired commands; legal range 1..8.
REQ-004 SHALL have parameter STALL_EVERY, default 0: after every N accepted commands, cmd_ready drops for one cycle; 0 disables the stall.
REQ-005 SHALL have port nice_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port nice_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port icb_cmd_valid, input, 1 bit: command request.
REQ-008 SHALL have port icb_cmd_ready, output, 1 bit: command accept.
REQ-009 SHALL have port icb_cmd_addr, input, 32 bits: byte address.
REQ-010 SHALL have port icb_cmd_read, input, 1 bit: 1 = read, 0 = write.
REQ-011 SHALL have port icb_cmd_wdata, input, 32 bits: write data.
REQ-012 SHALL have port icb_cmd_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = illegal.
REQ-013 SHALL have port icb_rsp_valid, output, 1 bit: response valid.
REQ-014 SHALL have port icb_rsp_ready, input, 1 bit: response accept.
REQ-015 SHALL have port icb_rsp_rdata, output, 32 bits: read data.
REQ-016 SHALL have port icb_rsp_err, output, 1 bit: error flag for the presented response.
REQ-017 SHALL have port bk_wr_en, input, 1 bit: backdoor byte-write strobe for preload.
REQ-018 SHALL have port bk_addr, input, 32 bits: backdoor byte address.
REQ-019 SHALL have port bk_wdata, input, 8 bits: backdoor byte data.
REQ-020 SHALL have port pend_cnt, output, 4 bits: current outstanding-command count.
REQ-021 SHALL have port err_cnt, output, 16 bits: saturating count of errored responses retired.

Function
REQ-022 SHALL accept a command on a cycle where icb_cmd_valid and icb_cmd_ready are both 1.
REQ-023 SHALL drive icb_cmd_ready only from registered state: 1 iff pend_cnt < OUTSTANDING and no stall cycle is active; no combinational path from icb_rsp_ready.
REQ-024 SHALL perform reads and writes on the memory array in the accept cycle, so a read accepted after a write sees the written data.
REQ-025 SHALL use big-endian byte lanes: a word read returns {mem[a], mem[a+1], mem[a+2], mem[a+3]}; a half read returns {16'b0, mem[a], mem[a+1]}; a byte read returns {24'b0, mem[a]}.
REQ-026 SHALL write with the same lane mapping: word writes wdata[31:24] to byte a; half writes wdata[15:8] to byte a; byte writes wdata[7:0] to byte a.
REQ-027 SHALL flag an error, with rdata 0 and no memory write, when size = 3, when the address is misaligned for the size, or when a + bytes > MEM_BYTES.
REQ-028 SHALL place each accepted command's result in an in-order response queue of depth OUTSTANDING, tagged with an age timer.
REQ-029 SHALL assert icb_rsp_valid for the queue head once it has aged at least RSP_LAT cycles; with RSP_LAT = 1 and an empty queue, valid rises the cycle after accept.
REQ-030 SHALL hold icb_rsp_valid, icb_rsp_rdata and icb_rsp_err stable until icb_rsp_ready is 1, then retire the head; the next head may present in the following cycle if already aged.
REQ-031 SHALL update pend_cnt by +1 per accept and −1 per retire; on simultaneous accept and retire it holds its value.
REQ-032 SHALL count accepted commands modulo STALL_EVERY and deassert icb_cmd_ready for exactly the one cycle following each Nth accept.
REQ-033 SHALL ignore a backdoor write whose bk_addr ≥ MEM_BYTES; on a same-cycle collision on the same byte, the backdoor write wins.
REQ-034 SHALL saturate err_cnt at 0xFFFF.

Reset
REQ-035 SHALL, on nice_rst_n low at any time, immediately clear the queue, drive icb_rsp_valid 0, rdata 0, err 0, pend_cnt 0, err_cnt 0, clear the stall counter, and drive icb_cmd_ready 0 while reset is asserted.
REQ-036 SHALL NOT clear memory contents on reset; preloaded data survives a mid-operation reset.
REQ-037 SHALL drive icb_cmd_ready 1 in the first cycle after reset release.

Verification
REQ-038 SHALL be verified by: backdoor load bytes 0x00..0x03 = 01,02,03,04, then word read at 0 -> rdata 0x01020304, err 0, valid 1 cycle after accept (RSP_LAT = 1).
REQ-039 SHALL be verified by: RSP_LAT = 3, OUTSTANDING = 2, three back-to-back reads with rsp_ready 0 -> cmd_ready drops after the 2nd accept, pend_cnt = 2, responses retire in order.
REQ-040 SHALL be verified by: word write 0xAABBCCDD to 0x10, then byte read 0x12 -> 0x000000CC, and half read 0x10 -> 0x0000AABB.
REQ-041 SHALL be verified by: word read at 0x2, size 3 at 0, and word read at MEM_BYTES−2 -> three responses with err 1, rdata 0, err_cnt = 3.
REQ-042 SHALL be verified by: STALL_EVERY = 4 with continuous valid -> cmd_ready low exactly one cycle after each 4th accept.
REQ-043 SHALL be verified by: asserting reset with 2 pending responses -> valid 0 and pend_cnt 0 immediately; after release, a read returns the pre-reset memory data.
